// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration helpers for the flagged FIFO family.

// Elaboration-time legality check; LBL names the generate block so several
// checks can coexist in one module.
`define FIFO_PARAM_CHECK(LBL, COND, MSG) \
   if (!(COND)) begin : LBL \
      $error(MSG); \
   end

package fifo_pkg;

   localparam int FIFO_DATA_W = 40;
   localparam int FIFO_ADDR_W = 6;

   // Bits needed to hold an occupancy value in 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// 1-write / 1-async-read storage array for the FIFO. Contents are not reset.

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Registered write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Show-ahead read: the head word is visible without a read strobe.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous show-ahead FIFO with true occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags.

module fifo_flagged
   import fifo_pkg::*;
#(
   parameter int DATA_W   = FIFO_DATA_W,
   parameter int ADDR_W   = FIFO_ADDR_W,
   parameter int AF_LEVEL = (1 << ADDR_W) - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = fifo_cnt_w(DEPTH);

   `FIFO_PARAM_CHECK(g_chk_addr, ADDR_W >= 2, "fifo_flagged: ADDR_W must be >= 2")
   `FIFO_PARAM_CHECK(g_chk_lvl, (AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH),
                     "fifo_flagged: need 0 < AE_LEVEL < AF_LEVEL <= DEPTH")
   `FIFO_PARAM_CHECK(g_chk_cnt, CNT_W == ADDR_W + 1, "fifo_flagged: count width mismatch")

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push_ok, pop_ok;

   // Flags come from the registered count only, so push/pop never feed them.
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A pop frees the slot this cycle, so a full FIFO still takes push+pop.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .we    (push_ok && !flush),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (dout)
   );

   // Pointers, occupancy and sticky error state; flush overrides push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
         if (push && full && !pop) overflow  <= 1'b1;
         if (pop && empty)         underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: queue-based reference model checked every
// cycle, plus literal expectations at the interesting points.

module tb_fifo_flagged;

   localparam int DW    = 40;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flush = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [AW:0]   count;

   int n_pass = 0;
   int n_total = 0;

   fifo_flagged #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(DEPTH-4), .AE_LEVEL(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .din(din), .pop(pop),
      .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Reference model: an ordered queue plus two sticky bits.
   logic [DW-1:0] q [$];
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ovf <= 1'b0;
         m_udf <= 1'b0;
      end else if (flush) begin
         q.delete();
         m_ovf <= 1'b0;
         m_udf <= 1'b0;
      end else begin
         automatic int  sz = q.size();
         automatic bit  do_pop  = pop && (sz > 0);
         automatic bit  do_push = push && ((sz < DEPTH) || pop);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(din);
         if (push && (sz == DEPTH) && !pop) m_ovf <= 1'b1;
         if (pop && (sz == 0)) m_udf <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      automatic int sz = q.size();
      chk("m_count", 64'(count), 64'(sz));
      chk("m_empty", 64'(empty), 64'(sz == 0));
      chk("m_full", 64'(full), 64'(sz == DEPTH));
      chk("m_afull", 64'(almost_full), 64'(sz >= DEPTH - 4));
      chk("m_aempty", 64'(almost_empty), 64'(sz <= 4));
      chk("m_ovf", 64'(overflow), 64'(m_ovf));
      chk("m_udf", 64'(underflow), 64'(m_udf));
      if (sz > 0) chk("m_dout", 64'(dout), 64'(q[0]));
   end

   task automatic step(input logic p, input logic [DW-1:0] d, input logic o, input logic f);
      push = p; din = d; pop = o; flush = f;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0;
   endtask

   initial begin
      // Power-on reset.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;

      // Underflow on empty, then 10 pushes, then reset between edges.
      step(0, '0, 1, 0);
      chk("udf_set", 64'(underflow), 64'd1);
      for (int i = 0; i < 10; i++) step(1, DW'(i + 1), 0, 0);
      chk("fill10", 64'(count), 64'd10);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_empty", 64'(empty), 64'd1);
      chk("mid_rst_udf", 64'(underflow), 64'd0);
      chk("mid_rst_ovf", 64'(overflow), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Fill to full with 0..63, watching almost_full cross at 60.
      for (int i = 0; i < DEPTH; i++) begin
         step(1, DW'(i), 0, 0);
         if (i == 58) chk("af_at_59", 64'(almost_full), 64'd0);
         if (i == 59) chk("af_at_60", 64'(almost_full), 64'd1);
      end
      chk("full_64", 64'(full), 64'd1);
      step(1, DW'(999), 0, 0);
      chk("ovf_65th", 64'(overflow), 64'd1);
      chk("count_65th", 64'(count), 64'd64);
      for (int i = 0; i < DEPTH; i++) begin
         if (i % 16 == 0) chk("drain_order", 64'(dout), 64'(i));
         step(0, '0, 1, 0);
      end
      chk("drained", 64'(empty), 64'd1);

      // Full with simultaneous push/pop.
      for (int i = 0; i < DEPTH; i++) step(1, DW'(256 + i), 0, 0);
      chk("full_head", 64'(dout), 64'h100);
      step(1, DW'(8'hAA), 1, 0);
      chk("full_both_cnt", 64'(count), 64'd64);
      chk("full_both_full", 64'(full), 64'd1);
      chk("full_both_head", 64'(dout), 64'h101);
      for (int i = 0; i < DEPTH - 1; i++) step(0, '0, 1, 0);
      chk("aa_emerges", 64'(dout), 64'hAA);
      step(0, '0, 1, 0);

      // Empty with simultaneous push/pop.
      step(0, '0, 0, 1);
      chk("flush_udf", 64'(underflow), 64'd0);
      step(1, DW'(8'h55), 1, 0);
      chk("empty_both_cnt", 64'(count), 64'd1);
      chk("empty_both_udf", 64'(underflow), 64'd1);
      chk("empty_both_dout", 64'(dout), 64'h55);

      // Wrap-around: bursty traffic carrying the write pointer past index 63.
      for (int c = 0; c < 100; c++)
         step((c % 4) != 3, {$urandom, 8'(c)}, (c % 4) >= 1, 0);
      while (q.size() > 0) step(0, '0, 1, 0);

      // Flush with push and pop high at count 20 and overflow set.
      step(0, '0, 0, 1);
      for (int i = 0; i < DEPTH + 1; i++) step(1, DW'(i), 0, 0);
      for (int i = 0; i < DEPTH - 20; i++) step(0, '0, 1, 0);
      chk("pre_flush_cnt", 64'(count), 64'd20);
      chk("pre_flush_ovf", 64'(overflow), 64'd1);
      step(1, DW'(40'hDEAD), 1, 1);
      chk("flush_cnt", 64'(count), 64'd0);
      chk("flush_empty", 64'(empty), 64'd1);
      chk("flush_ovf", 64'(overflow), 64'd0);
      step(0, '0, 0, 0);
      chk("flush_stays", 64'(count), 64'd0);
      step(1, DW'(40'h77), 0, 0);
      chk("post_flush_dout", 64'(dout), 64'h77);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
